clocked_reg_file: RTL
=====================

CLOCKED_REG_FILE -- requirements
Module: clocked_reg_file

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, data bits per word (>=1).
REQ-002 Parameter DEPTH SHALL be: DEPTH, default 8, number of words (power of two, >=2).
REQ-003 Parameter BYPASS SHALL be: BYPASS, default 1, 1 enables write-to-read forwarding.
REQ-004 The design SHALL derive AW = clog2(DEPTH) as a local constant, not a parameter.
REQ-005 The module SHALL have exactly one clock domain; the reset SHALL be asynchronous and active-low.
REQ-006 Port CLK SHALL be: CLK  input  1  clock, all state on rising edge.
REQ-007 Port RSTn SHALL be: RSTn  input  1  asynchronous active-low reset.
REQ-008 Port WE SHALL be: WE  input  1  write request.
REQ-009 Port WADDR SHALL be: WADDR  input  AW  write address.
REQ-010 Port WDATA SHALL be: WDATA  input  WIDTH  write data.
REQ-011 Port RADDR0 SHALL be: RADDR0  input  AW  read port 0 address.
REQ-012 Port RADDR1 SHALL be: RADDR1  input  AW  read port 1 address.
REQ-013 Port RDATA0 SHALL be: RDATA0  output  WIDTH  read port 0 data, combinational.
REQ-014 Port RDATA1 SHALL be: RDATA1  output  WIDTH  read port 1 data, combinational.
REQ-015 Port CLR SHALL be: CLR  input  1  request a sweep clear of all words.
REQ-016 Port BUSY SHALL be: BUSY  output  1  clear sweep in progress, registered.
REQ-017 Port DONE SHALL be: DONE  output  1  one-cycle pulse when the sweep completes, registered.
REQ-018 Port WERR SHALL be: WERR  output  1  one-cycle pulse flagging a rejected write, registered.

Function
REQ-019 A write SHALL be accepted when WE=1 in state IDLE and CLR=0; the word at WADDR SHALL take WDATA at that rising edge.
REQ-020 Reads SHALL be asynchronous; RDATAx SHALL equal the word at RADDRx, so an accepted write is visible from the cycle after the edge.
REQ-021 With BYPASS=1, an accepted write and WADDR==RADDRx SHALL drive RDATAx = WDATA in the same cycle; both ports SHALL bypass independently.
REQ-022 The sequencer SHALL have states IDLE, CLEAR and FIN.
REQ-023 IDLE SHALL move to CLEAR when CLR=1, loading sweep counter 0.
REQ-024 In CLEAR, each cycle SHALL zero the word at the counter and increment it.
REQ-025 CLEAR SHALL move to FIN on the edge that zeroes word DEPTH-1.
REQ-026 FIN SHALL last one cycle and then return to IDLE.
REQ-027 BUSY SHALL be 1 exactly in CLEAR, i.e. DEPTH cycles; DONE SHALL be 1 exactly in FIN.
REQ-028 CLR SHALL be ignored in CLEAR and FIN, with no restart; a new CLR SHALL be honoured from IDLE only.
REQ-029 WE=1 in CLEAR or FIN, or together with CLR in IDLE (CLR wins), SHALL be dropped; WERR SHALL pulse 1 on the next cycle and no word SHALL change from the write.
REQ-030 Reads during a sweep SHALL return current contents: zero for swept words and old data for unswept words; no bypass SHALL occur for dropped writes.
REQ-031 The sweep counter SHALL be AW bits wide and SHALL NOT wrap past DEPTH-1 within a sweep.

Reset
REQ-032 When RSTn=0, all words SHALL be set to 0 immediately, the state SHALL be IDLE, the counter 0, and BUSY, DONE and WERR 0.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep, with no DONE pulse after release.
REQ-034 The first accepted write SHALL be on the first rising edge with RSTn=1.

Structure
REQ-035 Shared package reg_file_pkg SHALL hold the state encodings IDLE=2'b00, CLEAR=2'b01 and FIN=2'b10.
REQ-036 One sub-module, reg_file_clr_seq, SHALL contain the FSM, counter, BUSY, DONE and the write-accept qualifier; the storage array and read muxes SHALL stay in the top.

Verification (WIDTH=8, DEPTH=8)
REQ-037 Bench: release reset, write A5 to addr 3, then read RADDR0=3 -> RDATA0=A5 from the next cycle; all other addresses read 00.
REQ-038 Bench: BYPASS=1, WE with addr 5 and data 3C, RADDR1=5 in the same cycle -> RDATA1=3C that cycle; with BYPASS=0 -> old value 00 that cycle and 3C next cycle.
REQ-039 Bench: fill addrs 0-7 with FF, pulse CLR -> BUSY high 8 cycles, then DONE high 1 cycle; all words 00 afterwards; mid-sweep reads show 00 below the counter and FF above it.
REQ-040 Bench: WE with data 77 during BUSY, and WE together with CLR in IDLE -> WERR pulses once per event and the target words are unchanged.
REQ-041 Bench: RSTn low for 1 cycle during the 4th cycle of a sweep -> BUSY=0 and all words 00, no DONE; a CLR after release runs a full 8-cycle sweep.
REQ-042 Bench: CLR held high for 20 cycles -> sweeps with a 1-cycle IDLE gap each time, DONE pulse per sweep, and no restart mid-sweep.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types for the clocked register file: clear-sweep sequencer state encodings.
package reg_file_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CLEAR = 2'b01,
      FIN   = 2'b10
   } seq_state_e;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear-sweep sequencer: walks every word once on CLR, flags BUSY/DONE, and decides
// which writes are accepted versus dropped.
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic          i_clr,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_werr,
   output logic          o_we_ok_c,
   output logic          o_clr_en_c,
   output logic [AW-1:0] o_clr_addr_c
);

   seq_state_e    r_state;
   seq_state_e    w_state_next;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] w_cnt_next;
   logic          w_last;
   logic          w_we_ok;
   logic          r_busy;
   logic          r_done;
   logic          r_werr;

   assign w_last  = (r_cnt == AW'(DEPTH - 1));
   // Writes only land when idle and not competing with a clear request.
   assign w_we_ok = (r_state == IDLE) && i_we && !i_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_werr  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_busy  <= (w_state_next == CLEAR);
         r_done  <= (w_state_next == FIN);
         r_werr  <= i_we && !w_we_ok;
      end
   end

   // Counter holds at DEPTH-1 on the final sweep step and is reloaded on the next CLR.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         IDLE: begin
            if (i_clr) begin
               w_state_next = CLEAR;
               w_cnt_next   = '0;
            end
         end
         CLEAR: begin
            if (w_last) begin
               w_state_next = FIN;
            end else begin
               w_cnt_next = r_cnt + AW'(1);
            end
         end
         FIN: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_werr       = r_werr;
   assign o_we_ok_c    = w_we_ok;
   assign o_clr_en_c   = (r_state == CLEAR);
   assign o_clr_addr_c = r_cnt;

endmodule

// File: rtl/clocked_reg_file.sv
// One-write, two-read register file with optional write-to-read forwarding and a
// multi-cycle sweep clear driven by reg_file_clr_seq.
module clocked_reg_file
   import reg_file_pkg::*;
#(
   parameter  int unsigned WIDTH  = 8,
   parameter  int unsigned DEPTH  = 8,
   parameter  int unsigned BYPASS = 1,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             WE,
   input  logic [AW-1:0]    WADDR,
   input  logic [WIDTH-1:0] WDATA,
   input  logic [AW-1:0]    RADDR0,
   input  logic [AW-1:0]    RADDR1,
   output logic [WIDTH-1:0] RDATA0,
   output logic [WIDTH-1:0] RDATA1,
   input  logic             CLR,
   output logic             BUSY,
   output logic             DONE,
   output logic             WERR
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_we_ok;
   logic             w_clr_en;
   logic [AW-1:0]    w_clr_addr;
   logic [WIDTH-1:0] w_rd0;
   logic [WIDTH-1:0] w_rd1;

   reg_file_clr_seq #(
      .DEPTH (DEPTH)
   ) u_clr_seq (
      .clk          (CLK),
      .rst_n        (RSTn),
      .i_we         (WE),
      .i_clr        (CLR),
      .o_busy       (BUSY),
      .o_done       (DONE),
      .o_werr       (WERR),
      .o_we_ok_c    (w_we_ok),
      .o_clr_en_c   (w_clr_en),
      .o_clr_addr_c (w_clr_addr)
   );

   // Sweep and accepted write are mutually exclusive by construction.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_clr_en) begin
         r_mem[w_clr_addr] <= '0;
      end else if (w_we_ok) begin
         r_mem[WADDR] <= WDATA;
      end
   end

   // Asynchronous reads; each port forwards an accepted write to the same address.
   always_comb begin
      w_rd0 = r_mem[RADDR0];
      w_rd1 = r_mem[RADDR1];
      if ((BYPASS != 0) && w_we_ok && (WADDR == RADDR0)) begin
         w_rd0 = WDATA;
      end
      if ((BYPASS != 0) && w_we_ok && (WADDR == RADDR1)) begin
         w_rd1 = WDATA;
      end
   end

   assign RDATA0 = w_rd0;
   assign RDATA1 = w_rd1;

endmodule
